// File: rtl/jtag_seq_pkg.sv
// Shared definitions for the JTAG scan sequencer.
//   - jtag_op_e   : command opcodes carried on cmd_op
//   - *Len        : tck counts of the fixed TMS path fragments
//   - tap_state_e : IEEE 1149.1 TAP controller state encodings (4 bit)
//   - tap_next    : TAP controller transition function, for TAP models
package jtag_seq_pkg;

  typedef enum logic [1:0] {
    OpReset  = 2'd0,
    OpIrScan = 2'd1,
    OpDrScan = 2'd2,
    OpIdle   = 2'd3
  } jtag_op_e;

  // Fixed path lengths in tck periods.
  localparam int unsigned ResetLen   = 6;  // 1,1,1,1,1,0 : any state -> Run-Test/Idle
  localparam int unsigned DrHdrLen   = 3;  // 1,0,0       : RTI -> Shift-DR
  localparam int unsigned IrHdrLen   = 4;  // 1,1,0,0     : RTI -> Shift-IR
  localparam int unsigned TrailerLen = 2;  // 1,0         : Exit1 -> Update -> RTI

  typedef enum logic [3:0] {
    TapExit2Dr     = 4'h0,
    TapExit1Dr     = 4'h1,
    TapShiftDr     = 4'h2,
    TapPauseDr     = 4'h3,
    TapSelectIr    = 4'h4,
    TapUpdateDr    = 4'h5,
    TapCaptureDr   = 4'h6,
    TapSelectDr    = 4'h7,
    TapExit2Ir     = 4'h8,
    TapExit1Ir     = 4'h9,
    TapShiftIr     = 4'hA,
    TapPauseIr     = 4'hB,
    TapRunIdle     = 4'hC,
    TapUpdateIr    = 4'hD,
    TapCaptureIr   = 4'hE,
    TapLogicReset  = 4'hF
  } tap_state_e;

  function automatic tap_state_e tap_next(tap_state_e s, logic tms);
    tap_state_e n;
    case (s)
      TapLogicReset: n = tms ? TapLogicReset : TapRunIdle;
      TapRunIdle:    n = tms ? TapSelectDr   : TapRunIdle;
      TapSelectDr:   n = tms ? TapSelectIr   : TapCaptureDr;
      TapCaptureDr:  n = tms ? TapExit1Dr    : TapShiftDr;
      TapShiftDr:    n = tms ? TapExit1Dr    : TapShiftDr;
      TapExit1Dr:    n = tms ? TapUpdateDr   : TapPauseDr;
      TapPauseDr:    n = tms ? TapExit2Dr    : TapPauseDr;
      TapExit2Dr:    n = tms ? TapUpdateDr   : TapShiftDr;
      TapUpdateDr:   n = tms ? TapSelectDr   : TapRunIdle;
      TapSelectIr:   n = tms ? TapLogicReset : TapCaptureIr;
      TapCaptureIr:  n = tms ? TapExit1Ir    : TapShiftIr;
      TapShiftIr:    n = tms ? TapExit1Ir    : TapShiftIr;
      TapExit1Ir:    n = tms ? TapUpdateIr   : TapPauseIr;
      TapPauseIr:    n = tms ? TapExit2Ir    : TapPauseIr;
      TapExit2Ir:    n = tms ? TapUpdateIr   : TapShiftIr;
      TapUpdateIr:   n = tms ? TapSelectDr   : TapRunIdle;
      default:       n = TapLogicReset;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// Test clock generator: while en_i is high, tck_o runs with DIV clk cycles per half period,
// starting with a low phase. Strobes are valid in the clk cycle before the edge they name.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en_i       : run tck; low forces tck_o=0 and restarts the divider
//   tck_o      : test clock
//   rise_o     : the coming clk edge drives tck high (sample tdo)
//   fall_o     : the coming clk edge ends the high phase (next bit's low phase starts)
module jtag_tck_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(DIV) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tck_q, tck_d;
  logic            last;

  assign last = (cnt_q == CntW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = en_i & last & ~tck_q;
  assign fall_o = en_i & last & tck_q;

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Host-side JTAG master. Takes RESET / IR_SCAN / DR_SCAN / IDLE commands over valid/ready,
// walks the TAP along fixed TMS paths (always from and back to Run-Test/Idle) and returns the
// tdo bits captured during the shift, right-aligned, LSB first.
//   clk, rst_n           : system clock, asynchronous active-low reset
//   cmd_valid/ready      : command handshake; cmd_op, cmd_len (clamped to MAX_LEN), cmd_data
//   rsp_valid/ready      : response handshake; rsp_data held until accepted
//   tck, tms, tdi, tdo   : TAP pins
//   busy                 : a command is being sequenced
// Optional build macro JTAG_SEQ_AUTO_RESET_EN: until a RESET sequence has completed since
// rst_n, any other command is preceded by the 6-tck RESET path in the same run.
module jtag_scan_sequencer
  import jtag_seq_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 32,
  parameter  int unsigned DIV     = 2,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               busy
);

  localparam int unsigned IdxW = LEN_W + 3;
  typedef logic [IdxW-1:0] idx_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // Sequence helpers. idx counts tck periods from the start of the run, including any
  // auto-reset preamble (pre); j is the position inside the command's own path.
  function automatic logic in_preamble(logic pre, idx_t idx);
    return pre && (idx < idx_t'(ResetLen));
  endfunction

  function automatic idx_t seq_pos(logic pre, idx_t idx);
    return pre ? idx - idx_t'(ResetLen) : idx;
  endfunction

  function automatic idx_t hdr_len(jtag_op_e op);
    return (op == OpIrScan) ? idx_t'(IrHdrLen) : idx_t'(DrHdrLen);
  endfunction

  function automatic logic is_scan(jtag_op_e op);
    return (op == OpIrScan) || (op == OpDrScan);
  endfunction

  function automatic idx_t seq_total(jtag_op_e op, logic [LEN_W-1:0] n, logic pre);
    idx_t t;
    case (op)
      OpReset: t = idx_t'(ResetLen);
      OpIdle:  t = idx_t'(n);
      default: t = idx_t'(n) + hdr_len(op) + idx_t'(TrailerLen);
    endcase
    if (pre) t = t + idx_t'(ResetLen);
    return t;
  endfunction

  function automatic logic in_shift(jtag_op_e op, logic [LEN_W-1:0] n, logic pre, idx_t idx);
    idx_t j, h;
    j = seq_pos(pre, idx);
    h = hdr_len(op);
    return !in_preamble(pre, idx) && is_scan(op) && (j >= h) && (j < h + idx_t'(n));
  endfunction

  function automatic logic tms_at(jtag_op_e op, logic [LEN_W-1:0] n, logic pre, idx_t idx);
    idx_t j, h, nn;
    logic r;
    j  = seq_pos(pre, idx);
    h  = hdr_len(op);
    nn = idx_t'(n);
    r  = 1'b0;
    if (in_preamble(pre, idx)) begin
      r = (idx != idx_t'(ResetLen - 1));
    end else begin
      case (op)
        OpReset: r = (j != idx_t'(ResetLen - 1));
        OpIdle:  r = 1'b0;
        default: begin
          if (j < h - 1'b1)       r = (j == 0) || ((op == OpIrScan) && (j == 1));
          // Zero-length scan leaves Capture via Exit1 instead of entering Shift.
          else if (j == h - 1'b1) r = (nn == 0);
          else if (j < h + nn)    r = (j == h + nn - 1'b1);
          else                    r = (j == h + nn);
        end
      endcase
    end
    return r;
  endfunction

  function automatic logic tdi_at(jtag_op_e op, logic [LEN_W-1:0] n, logic pre,
                                  logic [MAX_LEN-1:0] data, idx_t idx);
    logic [MAX_LEN-1:0] sh;
    sh = data >> (seq_pos(pre, idx) - hdr_len(op));
    return in_shift(op, n, pre, idx) ? sh[0] : 1'b0;
  endfunction

  logic [1:0]         state_q, state_d;
  jtag_op_e           op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic               pre_q, pre_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  idx_t               bit_q, bit_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  jtag_op_e           op_in;
  logic [LEN_W-1:0]   len_in;
  logic               pre_in;
  idx_t               total_in, total_cur, nxt_idx;
  logic [MAX_LEN-1:0] rsp_bit;
  logic               gen_en, gen_rise, gen_fall;

`ifdef JTAG_SEQ_AUTO_RESET_EN
  logic synced_q, synced_d;
  assign pre_in = !synced_q && (op_in != OpReset);
`else
  assign pre_in = 1'b0;
`endif

  assign op_in     = jtag_op_e'(cmd_op);
  assign len_in    = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign total_in  = seq_total(op_in, len_in, pre_in);
  assign total_cur = seq_total(op_q, len_q, pre_q);
  assign nxt_idx   = bit_q + 1'b1;
  assign gen_en    = (state_q == StRun) && (total_cur != '0);

  always_comb begin
    rsp_bit    = '0;
    rsp_bit[0] = tdo;
  end

  jtag_tck_gen #(
    .DIV (DIV)
  ) u_tck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (gen_en),
    .tck_o  (tck),
    .rise_o (gen_rise),
    .fall_o (gen_fall)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    pre_d   = pre_q;
    rsp_d   = rsp_q;
    bit_d   = bit_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
`ifdef JTAG_SEQ_AUTO_RESET_EN
    synced_d = synced_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StRun;
          op_d    = op_in;
          len_d   = len_in;
          data_d  = cmd_data;
          pre_d   = pre_in;
          rsp_d   = '0;
          bit_d   = '0;
          // First bit's low phase starts on the accept edge; with no tck the pins stay put.
          if (total_in != '0) begin
            tms_d = tms_at(op_in, len_in, pre_in, '0);
            tdi_d = tdi_at(op_in, len_in, pre_in, cmd_data, '0);
          end
        end
      end
      StRun: begin
        if (total_cur == '0) begin
          state_d = StResp;
        end else begin
          if (gen_rise && in_shift(op_q, len_q, pre_q, bit_q)) begin
            rsp_d = rsp_q | (rsp_bit << (seq_pos(pre_q, bit_q) - hdr_len(op_q)));
          end
          if (gen_fall) begin
`ifdef JTAG_SEQ_AUTO_RESET_EN
            if ((bit_q == idx_t'(ResetLen - 1)) && ((op_q == OpReset) || pre_q)) begin
              synced_d = 1'b1;
            end
`endif
            if (bit_q == total_cur - 1'b1) begin
              state_d = StResp;
            end else begin
              bit_d = nxt_idx;
              tms_d = tms_at(op_q, len_q, pre_q, nxt_idx);
              tdi_d = tdi_at(op_q, len_q, pre_q, data_q, nxt_idx);
            end
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpReset;
      len_q   <= '0;
      data_q  <= '0;
      pre_q   <= 1'b0;
      rsp_q   <= '0;
      bit_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      pre_q   <= pre_d;
      rsp_q   <= rsp_d;
      bit_q   <= bit_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

`ifdef JTAG_SEQ_AUTO_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) synced_q <= 1'b0;
    else        synced_q <= synced_d;
  end
`endif

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: a behavioural TAP (8-bit DR, 4-bit IR) hangs off the pins;
// each command pushes its expected response, tck count, tms path and latency to a queue,
// which is popped and compared when rsp_valid appears.
module tb_jtag_scan_sequencer;
  import jtag_seq_pkg::*;

  localparam int unsigned MaxLen = 32;
  localparam int unsigned Div    = 2;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);
  localparam logic [7:0]  DrCap  = 8'h3C;
  localparam logic [3:0]  IrCap  = 4'h1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [LenW-1:0]   cmd_len = '0;
  logic [MaxLen-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [MaxLen-1:0] rsp_data;
  logic              tck, tms, tdi, tdo, busy;

  always #5 clk = ~clk;

  jtag_scan_sequencer #(
    .MAX_LEN (MaxLen),
    .DIV     (Div)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .busy      (busy)
  );

  // Behavioural TAP, starting somewhere other than Run-Test/Idle.
  tap_state_e tap_st = TapPauseDr;
  logic [7:0] dr_sh = 8'h00, dr_reg = 8'h00;
  logic [3:0] ir_sh = 4'h0,  ir_reg = 4'h0;

  assign tdo = (tap_st == TapShiftDr) ? dr_sh[0] :
               (tap_st == TapShiftIr) ? ir_sh[0] : 1'b0;

  always @(posedge tck) begin
    case (tap_st)
      TapCaptureDr: dr_sh  <= DrCap;
      TapShiftDr:   dr_sh  <= {tdi, dr_sh[7:1]};
      TapUpdateDr:  dr_reg <= dr_sh;
      TapCaptureIr: ir_sh  <= IrCap;
      TapShiftIr:   ir_sh  <= {tdi, ir_sh[3:1]};
      TapUpdateIr:  ir_reg <= ir_sh;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  // Every tck rise logs the tms value seen by the TAP.
  int   tck_total = 0;
  logic hist [0:4095];
  always @(posedge tck) begin
    if (tck_total < 4096) hist[tck_total[11:0]] = tms;
    tck_total = tck_total + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rsp;
    int          ntck;
    logic [63:0] tms;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int   start_tck;

  function automatic void push_bit(inout logic [63:0] seq, inout int cnt, input logic b);
    if (cnt < 64) seq[cnt[5:0]] = b;
    cnt++;
  endfunction

  // TMS path written out piecewise from the command description.
  function automatic void build_tms(input jtag_op_e op, input int n, input bit pre,
                                    output logic [63:0] seq, output int cnt);
    seq = '0;
    cnt = 0;
    if (pre || op == OpReset) begin
      for (int i = 0; i < 5; i++) push_bit(seq, cnt, 1'b1);
      push_bit(seq, cnt, 1'b0);
    end
    if (op == OpIdle) begin
      for (int i = 0; i < n; i++) push_bit(seq, cnt, 1'b0);
    end else if (op != OpReset) begin
      push_bit(seq, cnt, 1'b1);
      if (op == OpIrScan) push_bit(seq, cnt, 1'b1);
      push_bit(seq, cnt, 1'b0);
      if (n == 0) begin
        push_bit(seq, cnt, 1'b1);
      end else begin
        push_bit(seq, cnt, 1'b0);
        for (int i = 0; i < n; i++) push_bit(seq, cnt, (i == n - 1));
      end
      push_bit(seq, cnt, 1'b1);
      push_bit(seq, cnt, 1'b0);
    end
  endfunction

  // Captured bits come out first, then the bits we shifted in, truncated to n.
  function automatic logic [31:0] scan_rsp(input logic [31:0] cap, input int w,
                                           input logic [31:0] data, input int n);
    logic [63:0] t;
    logic [31:0] r;
    t = ({32'b0, data} << w) | {32'b0, cap};
    r = '0;
    for (int i = 0; i < n; i++) r[i] = t[i];
    return r;
  endfunction

  task automatic send(input jtag_op_e op, input int len, input logic [31:0] data,
                      input bit pre, input logic [31:0] exp_rsp);
    exp_t        e;
    int          n, cnt;
    logic [63:0] seq;
    n = (len > int'(MaxLen)) ? int'(MaxLen) : len;
    build_tms(op, n, pre, seq, cnt);
    e.rsp  = exp_rsp;
    e.ntck = cnt;
    e.tms  = seq;
    e.lat  = (cnt == 0) ? 1 : cnt * 2 * int'(Div);
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LenW'(len);
    cmd_data  = data;
    @(posedge clk);
    start_tck = tck_total;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold);
    exp_t        e;
    int          lat, cnt;
    logic [63:0] got_seq;
    lat = 0;
    @(negedge clk);
    check_eq("busy_run", busy, 1'b1);
    check_eq("cmd_ready_run", cmd_ready, 1'b0);
    while (!rsp_valid && lat < 5000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!rsp_valid) begin
      check_eq("rsp_timeout", rsp_valid, 1'b1);
      return;
    end
    cnt     = tck_total - start_tck;
    got_seq = '0;
    for (int i = 0; i < 64; i++) if (i < cnt) got_seq[i] = hist[(start_tck + i) % 4096];
    check_eq("rsp_data", rsp_data, e.rsp);
    check_eq("tck_count", cnt, e.ntck);
    check_eq("tms_path", got_seq, e.tms);
    check_eq("latency", lat, e.lat);
    check_eq("tck_low_resp", tck, 1'b0);
    check_eq("busy_resp", busy, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_data", rsp_data, e.rsp);
      check_eq("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rsp_valid_drop", rsp_valid, 1'b0);
    check_eq("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_data", rsp_data, '0);
    check_eq("rst_tck", tck, 1'b0);
    check_eq("rst_tms", tms, 1'b1);
    check_eq("rst_tdi", tdi, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(OpReset, 0, 32'h0, 1'b0, 32'h0);
    wait_rsp(0);
    check_eq("tap_after_reset", tap_st, TapRunIdle);

    send(OpDrScan, 8, 32'hA5, 1'b0, scan_rsp({24'b0, DrCap}, 8, 32'hA5, 8));
    wait_rsp(0);
    check_eq("dr_reg_a5", dr_reg, 8'hA5);
    check_eq("tap_after_dr", tap_st, TapRunIdle);

    send(OpIrScan, 4, 32'hA, 1'b0, scan_rsp({28'b0, IrCap}, 4, 32'hA, 4));
    wait_rsp(0);
    check_eq("ir_reg_a", ir_reg, 4'hA);
    check_eq("tap_after_ir", tap_st, TapRunIdle);

    send(OpIdle, 0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    wait_rsp(0);

    send(OpDrScan, 0, 32'h0, 1'b0, 32'h0);
    wait_rsp(0);
    check_eq("dr_reg_len0", dr_reg, DrCap);
    check_eq("tap_after_dr0", tap_st, TapRunIdle);

    send(OpIdle, 3, 32'hFFFF_FFFF, 1'b0, 32'h0);
    wait_rsp(0);

    rsp_ready = 1'b0;
    send(OpDrScan, 40, 32'hDEAD_BEEF, 1'b0, scan_rsp({24'b0, DrCap}, 8, 32'hDEAD_BEEF, 32));
    wait_rsp(20);
    check_eq("dr_reg_clamped", dr_reg, 8'hDE);
    check_eq("tap_after_dr40", tap_st, TapRunIdle);

    // Abort in the high phase of DR shift bit 4.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OpDrScan;
    cmd_len   = LenW'(8);
    cmd_data  = 32'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_eq("pre_abort_busy", busy, 1'b1);
    check_eq("pre_abort_tck", tck, 1'b1);
    check_eq("pre_abort_tms", tms, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_tck", tck, 1'b0);
    check_eq("abort_tms", tms, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_cmd_ready", cmd_ready, 1'b1);
    check_eq("abort_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("abort_no_rsp", rsp_valid, 1'b0);

`ifdef JTAG_SEQ_AUTO_RESET_EN
    send(OpDrScan, 8, 32'h5A, 1'b1, scan_rsp({24'b0, DrCap}, 8, 32'h5A, 8));
    wait_rsp(0);
`else
    send(OpReset, 0, 32'h0, 1'b0, 32'h0);
    wait_rsp(0);
    send(OpDrScan, 8, 32'h5A, 1'b0, scan_rsp({24'b0, DrCap}, 8, 32'h5A, 8));
    wait_rsp(0);
`endif
    check_eq("dr_reg_5a", dr_reg, 8'h5A);
    check_eq("tap_after_recover", tap_st, TapRunIdle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
